// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian words from a host link,
// writes them into instruction memory and holds the CPU in reset until loaded.
module program_loader #(
   parameter int                    MEMORY_DEPTH = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(32'h0040_0000)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [7:0]            byte_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic                  mem_write_o,
   output logic [DATA_WIDTH-1:0] mem_address_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  cpu_reset_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [15:0]           words_written_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_LO,
      S_HDR_HI,
      S_BYTES,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [15:0]           count_q, count_d;
   logic [1:0]            idx_q, idx_d;
   logic [23:0]           word_q, word_d;
   logic [15:0]           words_written_q, words_written_d;
   logic [DATA_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

   logic        accept;
   logic [15:0] hdr_count;
   logic        can_start;

   assign accept    = byte_valid_i & byte_ready_o;
   assign hdr_count = {byte_i, count_q[7:0]};
   assign can_start = start_i & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         count_q         <= '0;
         idx_q           <= '0;
         word_q          <= '0;
         words_written_q <= '0;
         mem_address_q   <= BASE_ADDRESS;
         mem_data_q      <= '0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         idx_q           <= idx_d;
         word_q          <= word_d;
         words_written_q <= words_written_d;
         mem_address_q   <= mem_address_d;
         mem_data_q      <= mem_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start_i) state_d = S_HDR_LO;
         S_HDR_LO: if (accept) state_d = S_HDR_HI;
         S_HDR_HI: begin
            if (accept) begin
               if (hdr_count == 16'd0)
                  state_d = S_DONE;
               else if (hdr_count > 16'(MEMORY_DEPTH))
                  state_d = S_ERROR;
               else
                  state_d = S_BYTES;
            end
         end
         S_BYTES:  if (accept && idx_q == 2'd3) state_d = S_WRITE;
         S_WRITE:  state_d = ((words_written_q + 16'd1) < count_q) ? S_BYTES : S_DONE;
         S_DONE,
         S_ERROR:  if (start_i) state_d = S_HDR_LO;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath: the fourth byte bypasses the lane register and forms the
   // write word directly, so the strobe can follow in the very next cycle.
   always_comb begin
      count_d         = count_q;
      idx_d           = idx_q;
      word_d          = word_q;
      words_written_d = words_written_q;
      mem_address_d   = mem_address_q;
      mem_data_d      = mem_data_q;
      if (can_start) words_written_d = '0;
      if (state_q == S_HDR_LO && accept) count_d[7:0] = byte_i;
      if (state_q == S_HDR_HI && accept) begin
         count_d[15:8] = byte_i;
         idx_d         = '0;
      end
      if (state_q == S_BYTES && accept) begin
         idx_d = idx_q + 2'd1;
         unique case (idx_q)
            2'd0: word_d[7:0]   = byte_i;
            2'd1: word_d[15:8]  = byte_i;
            2'd2: word_d[23:16] = byte_i;
            default: begin
               mem_data_d    = DATA_WIDTH'({byte_i, word_q});
               mem_address_d = BASE_ADDRESS + (DATA_WIDTH'(words_written_q) << 2);
            end
         endcase
      end
      if (state_q == S_WRITE) words_written_d = words_written_q + 16'd1;
   end

   always_comb begin
      byte_ready_o = 1'b0;
      mem_write_o  = 1'b0;
      cpu_reset_o  = 1'b1;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      error_o      = 1'b0;
      unique case (state_q)
         S_HDR_LO, S_HDR_HI, S_BYTES: begin
            byte_ready_o = 1'b1;
            busy_o       = 1'b1;
         end
         S_WRITE: begin
            mem_write_o = 1'b1;
            busy_o      = 1'b1;
         end
         S_DONE: begin
            done_o      = 1'b1;
            cpu_reset_o = 1'b0;
         end
         S_ERROR: error_o = 1'b1;
         default: ;
      endcase
   end

   assign mem_address_o   = mem_address_q;
   assign mem_data_o      = mem_data_q;
   assign words_written_o = words_written_q;

endmodule
